// File: rtl/nb_cid_scan.sv
// rtl/nb_cid_scan.sv - multi-fold neighbour cell ID scanner with a valid/ready result stream
// One source cell ID is evaluated against every home fold; one beat per fold is streamed out.
module nb_cid_scan #(
  parameter int NUM_FOLDS = 2,
  parameter int GCID_W    = 3,
  parameter int CID_W     = 2,
  parameter int X_GDIM    = 4,
  parameter int Y_GDIM    = 4,
  parameter int Z_GDIM    = 4,
  parameter int GCELL_X [NUM_FOLDS] = '{0, 1},
  parameter int GCELL_Y [NUM_FOLDS] = '{0, 1},
  parameter int GCELL_Z [NUM_FOLDS] = '{0, 1},
  parameter bit SKIP_MISS = 1'b1,
  localparam int FOLD_W = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_src_valid,
  output logic              o_src_ready,
  input  logic [GCID_W-1:0] i_src_gcid_x,
  input  logic [GCID_W-1:0] i_src_gcid_y,
  input  logic [GCID_W-1:0] i_src_gcid_z,
  output logic              o_nb_valid,
  input  logic              i_nb_ready,
  output logic [CID_W-1:0]  o_nb_cid_x,
  output logic [CID_W-1:0]  o_nb_cid_y,
  output logic [CID_W-1:0]  o_nb_cid_z,
  output logic [FOLD_W-1:0] o_nb_fold_id,
  output logic              o_nb_hit,
  output logic              o_nb_last,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, EVAL, EMIT} state_t;

  state_t               state, state_n;
  logic [GCID_W-1:0]    src_x, src_y, src_z;
  logic [NUM_FOLDS-1:0] mask, hit_c;
  logic [CID_W-1:0]     cid_x [NUM_FOLDS];
  logic [CID_W-1:0]     cid_y [NUM_FOLDS];
  logic [CID_W-1:0]     cid_z [NUM_FOLDS];
  logic [CID_W-1:0]     cx_c  [NUM_FOLDS];
  logic [CID_W-1:0]     cy_c  [NUM_FOLDS];
  logic [CID_W-1:0]     cz_c  [NUM_FOLDS];
  logic [FOLD_W-1:0]    ptr, ptr_n;
  logic                 nb_last;
  logic                 emit;
  logic                 beat_hit;

  // Returns {hit, cid}. The +1 test precedes the -1 test so a 2-cell ring reports +1.
  function automatic logic [CID_W:0] dim_cid(input logic [GCID_W-1:0] src, input int home,
                                             input int gdim);
    int d;
    d = int'(src);
    dim_cid = '0;
    if (d < gdim) begin
      d = d - home;
      if (d < 0) d = d + gdim;
      if (d == 0)             dim_cid = {1'b1, CID_W'(1)};
      else if (d == 1)        dim_cid = {1'b1, CID_W'(2)};
      else if (d == gdim - 1) dim_cid = {1'b1, CID_W'(0)};
    end
  endfunction

  function automatic logic [FOLD_W-1:0] first_set(input logic [NUM_FOLDS-1:0] m, input int from);
    first_set = '0;
    for (int i = NUM_FOLDS - 1; i >= 0; i--)
      if (i >= from && m[i]) first_set = FOLD_W'(i);
  endfunction

  function automatic logic any_set(input logic [NUM_FOLDS-1:0] m, input int from);
    any_set = 1'b0;
    for (int i = 0; i < NUM_FOLDS; i++)
      if (i >= from && m[i]) any_set = 1'b1;
  endfunction

  for (genvar f = 0; f < NUM_FOLDS; f++) begin : g_fold
    logic [CID_W:0] rx, ry, rz;
    assign rx       = dim_cid(src_x, GCELL_X[f], X_GDIM);
    assign ry       = dim_cid(src_y, GCELL_Y[f], Y_GDIM);
    assign rz       = dim_cid(src_z, GCELL_Z[f], Z_GDIM);
    assign hit_c[f] = rx[CID_W] & ry[CID_W] & rz[CID_W];
    assign cx_c[f]  = rx[CID_W-1:0];
    assign cy_c[f]  = ry[CID_W-1:0];
    assign cz_c[f]  = rz[CID_W-1:0];

    always_ff @(posedge clk) begin
      if (!rst)
        assert (GCELL_X[f] < X_GDIM && GCELL_Y[f] < Y_GDIM && GCELL_Z[f] < Z_GDIM)
          else $error("fold %0d home cell outside grid", f);
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    nb_last = SKIP_MISS ? !any_set(mask, int'(ptr) + 1) : (ptr == FOLD_W'(NUM_FOLDS - 1));
    case (state)
      IDLE: if (i_src_valid) state_n = EVAL;
      EVAL: begin
        state_n = EMIT;
        ptr_n   = SKIP_MISS ? first_set(hit_c, 0) : '0;
      end
      EMIT: if (i_nb_ready) begin
        if (nb_last) begin
          state_n = IDLE;
          ptr_n   = '0;
        end else begin
          ptr_n = SKIP_MISS ? first_set(mask, int'(ptr) + 1) : ptr + FOLD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      mask  <= '0;
      src_x <= '0;
      src_y <= '0;
      src_z <= '0;
      for (int f = 0; f < NUM_FOLDS; f++) begin
        cid_x[f] <= '0;
        cid_y[f] <= '0;
        cid_z[f] <= '0;
      end
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      if (state == IDLE && i_src_valid) begin
        src_x <= i_src_gcid_x;
        src_y <= i_src_gcid_y;
        src_z <= i_src_gcid_z;
      end
      if (state == EVAL) begin
        mask <= hit_c;
        for (int f = 0; f < NUM_FOLDS; f++) begin
          cid_x[f] <= cx_c[f];
          cid_y[f] <= cy_c[f];
          cid_z[f] <= cz_c[f];
        end
      end
    end
  end

  // Beat fields come straight from registers indexed by ptr, so they hold under backpressure.
  assign emit         = (state == EMIT);
  assign beat_hit     = emit & mask[ptr];
  assign o_src_ready  = (state == IDLE) & ~rst;
  assign o_busy       = (state != IDLE);
  assign o_nb_valid   = emit;
  assign o_nb_fold_id = emit ? ptr : '0;
  assign o_nb_hit     = beat_hit;
  assign o_nb_last    = emit & nb_last;
  assign o_nb_cid_x   = beat_hit ? cid_x[ptr] : '0;
  assign o_nb_cid_y   = beat_hit ? cid_y[ptr] : '0;
  assign o_nb_cid_z   = beat_hit ? cid_z[ptr] : '0;

  a_valid_hold: assert property (@(posedge clk) disable iff (rst)
    (o_nb_valid && !i_nb_ready) |=> o_nb_valid);
  a_beat_stable: assert property (@(posedge clk) disable iff (rst)
    (o_nb_valid && !i_nb_ready) |=>
      $stable({o_nb_fold_id, o_nb_cid_x, o_nb_cid_y, o_nb_cid_z, o_nb_hit, o_nb_last}));

endmodule

// File: tb/tb_nb_cid_scan.sv
// tb/tb_nb_cid_scan.sv - scoreboard bench for nb_cid_scan across several grid/fold configurations
// Stimulus pushes hand-computed beats; a negedge monitor pops them on each result handshake.
module tb_nb_cid_scan;

  typedef struct packed {
    logic       fold;
    logic [1:0] cx;
    logic [1:0] cy;
    logic [1:0] cz;
    logic       hit;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       src_valid = 1'b0;
  logic       nb_ready = 1'b1;
  logic [2:0] sel = 3'd0;
  logic [2:0] gx = 3'd0, gy = 3'd0, gz = 3'd0;

  logic [4:0]      src_ready_v, nb_valid_v, fold_v, hit_v, last_v, busy_v;
  logic [4:0][1:0] cx_v, cy_v, cz_v;

  logic       m_src_ready, m_nb_valid, m_fold, m_hit, m_last, m_busy;
  logic [1:0] m_cx, m_cy, m_cz;

  int    vectors = 0;
  int    fails = 0;
  beat_t exp_q [$];
  beat_t act, held, e;
  logic  stalled = 1'b0;
  logic  hs_prev = 1'b0;
  logic  hs_last_prev = 1'b0;

  always #5 clk = ~clk;

  assign m_src_ready = src_ready_v[sel];
  assign m_nb_valid  = nb_valid_v[sel];
  assign m_fold      = fold_v[sel];
  assign m_hit       = hit_v[sel];
  assign m_last      = last_v[sel];
  assign m_busy      = busy_v[sel];
  assign m_cx        = cx_v[sel];
  assign m_cy        = cy_v[sel];
  assign m_cz        = cz_v[sel];

  // a: GDIM 4, homes (0,0,0),(1,0,0), skip misses
  nb_cid_scan #(.GCELL_X('{0, 1}), .GCELL_Y('{0, 0}), .GCELL_Z('{0, 0}), .SKIP_MISS(1'b1)) u_a (
    .clk(clk), .rst(rst), .i_src_valid(src_valid && sel == 3'd0), .o_src_ready(src_ready_v[0]),
    .i_src_gcid_x(gx), .i_src_gcid_y(gy), .i_src_gcid_z(gz),
    .o_nb_valid(nb_valid_v[0]), .i_nb_ready(nb_ready),
    .o_nb_cid_x(cx_v[0]), .o_nb_cid_y(cy_v[0]), .o_nb_cid_z(cz_v[0]),
    .o_nb_fold_id(fold_v[0]), .o_nb_hit(hit_v[0]), .o_nb_last(last_v[0]), .o_busy(busy_v[0]));

  // b: GDIM 8, homes (0,0,0),(0,0,1), skip misses
  nb_cid_scan #(.X_GDIM(8), .Y_GDIM(8), .Z_GDIM(8), .GCELL_X('{0, 0}), .GCELL_Y('{0, 0}),
                .GCELL_Z('{0, 1}), .SKIP_MISS(1'b1)) u_b (
    .clk(clk), .rst(rst), .i_src_valid(src_valid && sel == 3'd1), .o_src_ready(src_ready_v[1]),
    .i_src_gcid_x(gx), .i_src_gcid_y(gy), .i_src_gcid_z(gz),
    .o_nb_valid(nb_valid_v[1]), .i_nb_ready(nb_ready),
    .o_nb_cid_x(cx_v[1]), .o_nb_cid_y(cy_v[1]), .o_nb_cid_z(cz_v[1]),
    .o_nb_fold_id(fold_v[1]), .o_nb_hit(hit_v[1]), .o_nb_last(last_v[1]), .o_busy(busy_v[1]));

  // c: as b but every fold emitted
  nb_cid_scan #(.X_GDIM(8), .Y_GDIM(8), .Z_GDIM(8), .GCELL_X('{0, 0}), .GCELL_Y('{0, 0}),
                .GCELL_Z('{0, 1}), .SKIP_MISS(1'b0)) u_c (
    .clk(clk), .rst(rst), .i_src_valid(src_valid && sel == 3'd2), .o_src_ready(src_ready_v[2]),
    .i_src_gcid_x(gx), .i_src_gcid_y(gy), .i_src_gcid_z(gz),
    .o_nb_valid(nb_valid_v[2]), .i_nb_ready(nb_ready),
    .o_nb_cid_x(cx_v[2]), .o_nb_cid_y(cy_v[2]), .o_nb_cid_z(cz_v[2]),
    .o_nb_fold_id(fold_v[2]), .o_nb_hit(hit_v[2]), .o_nb_last(last_v[2]), .o_busy(busy_v[2]));

  // d: GDIM 4, homes (1,1,1),(0,0,0), every fold emitted
  nb_cid_scan #(.GCELL_X('{1, 0}), .GCELL_Y('{1, 0}), .GCELL_Z('{1, 0}), .SKIP_MISS(1'b0)) u_d (
    .clk(clk), .rst(rst), .i_src_valid(src_valid && sel == 3'd3), .o_src_ready(src_ready_v[3]),
    .i_src_gcid_x(gx), .i_src_gcid_y(gy), .i_src_gcid_z(gz),
    .o_nb_valid(nb_valid_v[3]), .i_nb_ready(nb_ready),
    .o_nb_cid_x(cx_v[3]), .o_nb_cid_y(cy_v[3]), .o_nb_cid_z(cz_v[3]),
    .o_nb_fold_id(fold_v[3]), .o_nb_hit(hit_v[3]), .o_nb_last(last_v[3]), .o_busy(busy_v[3]));

  // e: GDIM (2,1,4), homes (0,0,0),(1,0,3), skip misses
  nb_cid_scan #(.X_GDIM(2), .Y_GDIM(1), .Z_GDIM(4), .GCELL_X('{0, 1}), .GCELL_Y('{0, 0}),
                .GCELL_Z('{0, 3}), .SKIP_MISS(1'b1)) u_e (
    .clk(clk), .rst(rst), .i_src_valid(src_valid && sel == 3'd4), .o_src_ready(src_ready_v[4]),
    .i_src_gcid_x(gx), .i_src_gcid_y(gy), .i_src_gcid_z(gz),
    .o_nb_valid(nb_valid_v[4]), .i_nb_ready(nb_ready),
    .o_nb_cid_x(cx_v[4]), .o_nb_cid_y(cy_v[4]), .o_nb_cid_z(cz_v[4]),
    .o_nb_fold_id(fold_v[4]), .o_nb_hit(hit_v[4]), .o_nb_last(last_v[4]), .o_busy(busy_v[4]));

  task automatic chk(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_beat(input int f, input int cx, input int cy, input int cz,
                           input int h, input int l);
    beat_t b;
    b.fold = 1'(f);
    b.cx   = 2'(cx);
    b.cy   = 2'(cy);
    b.cz   = 2'(cz);
    b.hit  = 1'(h);
    b.last = 1'(l);
    exp_q.push_back(b);
  endtask

  task automatic send(input int s, input int x, input int y, input int z, input int hold);
    int n;
    @(posedge clk); #1;
    sel = 3'(s);
    gx = 3'(x);
    gy = 3'(y);
    gz = 3'(z);
    src_valid = 1'b1;
    nb_ready = (hold == 0);
    n = 0;
    while (!m_src_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("src_ready_before_accept", int'(m_src_ready), 1);
    @(posedge clk); #1;
    src_valid = 1'b0;
    chk("eval_no_beat", int'(m_nb_valid), 0);
    chk("eval_src_ready", int'(m_src_ready), 0);
    @(posedge clk); #1;
    chk("first_beat_latency", int'(m_nb_valid), 1);
    if (hold > 0) begin
      repeat (hold - 1) @(posedge clk);
      #1;
      nb_ready = 1'b1;
    end
    n = 0;
    while (!m_src_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("returns_idle", int'(m_src_ready), 1);
    chk("all_beats_seen", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
      hs_prev = 1'b0;
    end else begin
      act = {m_fold, m_cx, m_cy, m_cz, m_hit, m_last};
      if (stalled) begin
        vectors++;
        if (!m_nb_valid || act != held) begin
          fails++;
          $display("FAIL beat_stable: got valid=%0d beat=%h expected valid=1 beat=%h",
                   m_nb_valid, act, held);
        end
      end
      if (hs_prev) chk("src_ready_after_beat", int'(m_src_ready), int'(hs_last_prev));
      stalled = m_nb_valid && !nb_ready;
      held = act;
      hs_prev = m_nb_valid && nb_ready;
      hs_last_prev = m_last;
      if (m_nb_valid && nb_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got fold=%0d cid=(%0d,%0d,%0d) hit=%0d last=%0d expected none",
                   m_fold, m_cx, m_cy, m_cz, m_hit, m_last);
        end else begin
          e = exp_q.pop_front();
          if (act != e) begin
            fails++;
            $display("FAIL beat: got fold=%0d cid=(%0d,%0d,%0d) hit=%0d last=%0d expected fold=%0d cid=(%0d,%0d,%0d) hit=%0d last=%0d",
                     act.fold, act.cx, act.cy, act.cz, act.hit, act.last,
                     e.fold, e.cx, e.cy, e.cz, e.hit, e.last);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(m_nb_valid), 0);
    chk("reset_busy", int'(m_busy), 0);
    chk("reset_hit", int'(m_hit), 0);
    chk("reset_last", int'(m_last), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_src_ready", int'(m_src_ready), 1);

    // reset in the middle of a stalled beat
    sel = 3'd0; gx = 3'd1; gy = 3'd0; gz = 3'd0; src_valid = 1'b1; nb_ready = 1'b0;
    @(posedge clk); #1;
    src_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_emit", int'(m_nb_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("midrst_valid", int'(m_nb_valid), 0);
    chk("midrst_busy", int'(m_busy), 0);
    chk("midrst_src_ready", int'(m_src_ready), 0);
    chk("midrst_beat", int'({m_fold, m_cx, m_cy, m_cz, m_hit, m_last}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_src_ready", int'(m_src_ready), 1);
    nb_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_stale_beat", int'(m_nb_valid), 0);
    chk("no_stale_busy", int'(m_busy), 0);

    // basic offsets, home (1,1,1)
    push_beat(0, 2, 1, 0, 1, 0); push_beat(1, 0, 0, 0, 0, 1);
    send(3, 2, 1, 0, 0);

    // periodic wrap and out-of-grid source
    push_beat(0, 0, 1, 1, 1, 1);
    send(0, 3, 0, 0, 0);
    push_beat(1, 2, 1, 1, 1, 1);
    send(0, 2, 0, 0, 0);
    push_beat(0, 0, 0, 0, 0, 1);
    send(0, 5, 0, 0, 0);

    // two hits under 3 cycles of backpressure
    push_beat(0, 2, 1, 1, 1, 0); push_beat(1, 1, 1, 1, 1, 1);
    send(0, 1, 0, 0, 3);
    push_beat(0, 1, 0, 2, 1, 0); push_beat(1, 0, 0, 2, 1, 1);
    send(0, 0, 3, 1, 0);

    // GDIM 8, skip misses
    push_beat(0, 0, 0, 0, 0, 1);
    send(1, 2, 2, 2, 0);
    push_beat(0, 0, 2, 1, 1, 0); push_beat(1, 0, 2, 0, 1, 1);
    send(1, 7, 1, 0, 0);
    push_beat(1, 1, 1, 2, 1, 1);
    send(1, 0, 0, 2, 0);

    // GDIM 8, every fold emitted
    push_beat(0, 0, 0, 0, 0, 0); push_beat(1, 0, 0, 0, 0, 1);
    send(2, 2, 2, 2, 0);
    push_beat(0, 0, 0, 0, 0, 0); push_beat(1, 1, 1, 2, 1, 1);
    send(2, 0, 0, 2, 0);
    push_beat(0, 0, 2, 1, 1, 0); push_beat(1, 0, 2, 0, 1, 1);
    send(2, 7, 1, 0, 2);

    // two-cell and one-cell rings
    push_beat(0, 2, 1, 1, 1, 0); push_beat(1, 1, 1, 2, 1, 1);
    send(4, 1, 0, 0, 0);
    push_beat(0, 1, 1, 0, 1, 0); push_beat(1, 2, 1, 1, 1, 1);
    send(4, 0, 0, 3, 0);
    push_beat(0, 0, 0, 0, 0, 1);
    send(4, 0, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
